// File: rtl/cla_pkg.sv
// Shared constants and types for the nibble-serial carry-lookahead adder.
// Holds the state encoding and the nibble counter width helper.
package cla_pkg;

  localparam int NIB_W = 4;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = IDLE,
    ST_RUN  = RUN,
    ST_DONE = DONE
  } state_e;

  function automatic int cnt_w(input int nibs);
    return (nibs > 1) ? $clog2(nibs) : 1;
  endfunction

endpackage

// File: rtl/cla4.sv
// Combinational 4-bit carry-lookahead adder slice.
// All carries come straight from generate/propagate terms.
module cla4 (
  input  logic [3:0] A_in,
  input  logic [3:0] B_in,
  input  logic       C_in,
  output logic [3:0] Sum_o,
  output logic       C_out
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  assign g = A_in & B_in;
  assign p = A_in ^ B_in;

  assign c[0] = C_in;
  assign c[1] = g[0]
              | (p[0] & C_in);
  assign c[2] = g[1]
              | (p[1] & g[0])
              | (p[1] & p[0] & C_in);
  assign c[3] = g[2]
              | (p[2] & g[1])
              | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & C_in);
  assign c[4] = g[3]
              | (p[3] & g[2])
              | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & C_in);

  assign Sum_o = p ^ c[3:0];
  assign C_out = c[4];

endmodule

// File: rtl/cla_seq_adder.sv
// Multi-cycle add/subtract unit reusing one 4-bit CLA slice per nibble.
// Subtraction runs as A + ~B + ~C_in so one slice serves both operations.
module cla_seq_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [WIDTH-1:0] A_in,
  input  logic [WIDTH-1:0] B_in,
  input  logic             C_in,
  input  logic             sub_i,
  output logic             ready_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] Sum_o,
  output logic             C_out,
  output logic             ovf_o
);

  import cla_pkg::*;

  localparam int NIBS = WIDTH / NIB_W;
  localparam int CW   = cnt_w(NIBS);
  localparam logic [CW-1:0] LAST = CW'(NIBS - 1);

  state_e state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             cy_q, cy_d;
  logic             sub_q, sub_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] b_sel;
  logic [NIB_W-1:0] s_nib;
  logic             c_nib;

  assign b_sel = sub_i ? ~B_in : B_in;

  cla4 u_cla4 (
    .A_in  (a_q[NIB_W-1:0]),
    .B_in  (b_q[NIB_W-1:0]),
    .C_in  (cy_q),
    .Sum_o (s_nib),
    .C_out (c_nib)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    cy_d    = cy_q;
    sub_d   = sub_q;
    res_d   = res_q;
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          a_d     = A_in;
          b_d     = b_sel;
          cy_d    = sub_i ? ~C_in : C_in;
          sub_d   = sub_i;
          cnt_d   = '0;
          a_msb_d = A_in[WIDTH-1];
          b_msb_d = b_sel[WIDTH-1];
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        res_d = WIDTH'({s_nib, res_q} >> NIB_W);
        a_d   = a_q >> NIB_W;
        b_d   = b_q >> NIB_W;
        cy_d  = c_nib;
        cnt_d = cnt_q + 1'b1;
        // last nibble lands straight in the output regs
        if (cnt_q == LAST) begin
          sum_d   = res_d;
          cout_d  = c_nib;
          ovf_d   = (a_msb_q == b_msb_q)
                 && (s_nib[NIB_W-1] != a_msb_q);
          done_d  = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cy_q    <= 1'b0;
      sub_q   <= 1'b0;
      res_q   <= '0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cy_q    <= cy_d;
      sub_q   <= sub_d;
      res_q   <= res_d;
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  assign ready_o = (state_q == ST_IDLE);
  assign busy_o  = (state_q == ST_RUN) & ~sub_q | (state_q == ST_RUN) & sub_q;
  assign done_o  = done_q;
  assign Sum_o   = sum_q;
  assign C_out   = cout_q;
  assign ovf_o   = ovf_q;

endmodule

// File: tb/tb_cla_seq_adder.sv
// Self-checking bench for cla_seq_adder (WIDTH=16) and standalone cla4.
// Directed handshake/reset steps plus a random sweep against an integer model.
module tb_cla_seq_adder;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         start_i;
  logic [W-1:0] A_in;
  logic [W-1:0] B_in;
  logic         C_in;
  logic         sub_i;
  logic         ready_o;
  logic         busy_o;
  logic         done_o;
  logic [W-1:0] Sum_o;
  logic         C_out;
  logic         ovf_o;

  logic [3:0] t_a;
  logic [3:0] t_b;
  logic       t_c;
  logic [3:0] t_s;
  logic       t_co;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cla_seq_adder #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .start_i (start_i),
    .A_in    (A_in),
    .B_in    (B_in),
    .C_in    (C_in),
    .sub_i   (sub_i),
    .ready_o (ready_o),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .Sum_o   (Sum_o),
    .C_out   (C_out),
    .ovf_o   (ovf_o)
  );

  cla4 u_c4 (
    .A_in  (t_a),
    .B_in  (t_b),
    .C_in  (t_c),
    .Sum_o (t_s),
    .C_out (t_co)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // {carry/no-borrow, signed overflow, sum} from plain integer arithmetic
  function automatic logic [17:0] model(input logic [15:0] a,
                                        input logic [15:0] b,
                                        input logic c,
                                        input logic s);
    logic [16:0] r;
    int   sr;
    logic co;
    logic ov;
    if (s) begin
      r  = {1'b0, a} - {1'b0, b} - {16'b0, c};
      co = ~r[16];
      sr = int'($signed(a)) - int'($signed(b)) - int'(c);
    end else begin
      r  = {1'b0, a} + {1'b0, b} + {16'b0, c};
      co = r[16];
      sr = int'($signed(a)) + int'($signed(b)) + int'(c);
    end
    ov = (sr > 32767) || (sr < -32768);
    return {co, ov, r[15:0]};
  endfunction

  task automatic issue(input logic [15:0] a, input logic [15:0] b,
                       input logic c, input logic s);
    A_in    = a;
    B_in    = b;
    C_in    = c;
    sub_i   = s;
    start_i = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    A_in    = W'($urandom);
    B_in    = W'($urandom);
    C_in    = 1'($urandom);
    sub_i   = 1'($urandom);
  endtask

  task automatic wait_done(output int lat);
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (done_o) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic op(input string tag, input logic [15:0] a,
                    input logic [15:0] b, input logic c, input logic s);
    int lat;
    logic [17:0] e;
    e = model(a, b, c, s);
    issue(a, b, c, s);
    wait_done(lat);
    chk({tag, " latency"}, lat, 5);
    chk({tag, " result"}, {14'b0, C_out, ovf_o, Sum_o}, {14'b0, e});
    @(negedge clk);
    chk({tag, " ready"}, {31'b0, ready_o}, 1);
  endtask

  initial begin
    int          lat;
    int          seen;
    logic [17:0] e;
    logic [8:0]  v;
    logic [15:0] ra;
    logic [15:0] rb;

    rst     = 1'b1;
    start_i = 1'b0;
    A_in    = '0;
    B_in    = '0;
    C_in    = 1'b0;
    sub_i   = 1'b0;

    for (int i = 0; i < 512; i++) begin
      v   = 9'(i);
      t_a = v[3:0];
      t_b = v[7:4];
      t_c = v[8];
      #1;
      chk("cla4", {27'b0, t_co, t_s},
          32'(t_a) + 32'(t_b) + 32'(t_c));
    end

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset state",
        {10'b0, ready_o, busy_o, done_o, C_out, ovf_o, Sum_o},
        {10'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0});

    op("add basic", 16'h1234, 16'h4321, 1'b0, 1'b0);
    chk("add basic sum", {16'b0, Sum_o}, 32'h5555);
    op("add carry", 16'hFFFF, 16'h0001, 1'b0, 1'b0);
    chk("add carry co", {31'b0, C_out}, 1);
    op("add ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0);
    chk("add ovf flag", {31'b0, ovf_o}, 1);
    op("sub bin", 16'h0010, 16'h000F, 1'b1, 1'b1);
    op("sub neg", 16'h0005, 16'h0007, 1'b0, 1'b1);
    chk("sub neg sum", {16'b0, Sum_o}, 32'hFFFE);
    op("sub ovf", 16'h8000, 16'h0001, 1'b0, 1'b1);
    chk("sub ovf sum", {16'b0, Sum_o}, 32'h7FFF);

    // starts during RUN must be ignored; outputs hold prior result
    e = model(16'h1111, 16'h2222, 1'b0, 1'b0);
    issue(16'h1111, 16'h2222, 1'b0, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk("hold sum", {16'b0, Sum_o}, 32'h7FFF);
      chk("hold done", {31'b0, done_o}, 0);
      chk("hold busy", {31'b0, busy_o}, 1);
      A_in    = W'($urandom);
      B_in    = W'($urandom);
      sub_i   = 1'($urandom);
      start_i = 1'b1;
    end
    @(negedge clk);
    start_i = 1'b0;
    chk("ignored done", {31'b0, done_o}, 1);
    chk("ignored result", {14'b0, C_out, ovf_o, Sum_o}, {14'b0, e});
    @(negedge clk);
    chk("ignored ready", {30'b0, ready_o, busy_o}, 32'h2);
    op("back2back", 16'hABCD, 16'h1357, 1'b1, 1'b0);

    // reset aborts an operation in flight
    issue(16'h0F0F, 16'h0101, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort state",
        {10'b0, ready_o, busy_o, done_o, C_out, ovf_o, Sum_o},
        {10'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0});
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      seen = seen | int'(done_o);
    end
    chk("abort no done", seen, 0);
    op("after abort", 16'h0F0F, 16'h0101, 1'b0, 1'b0);

    for (int i = 0; i < 2000; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      if (i % 8 == 0) rb = ~ra;
      if (i % 8 == 1) rb = ra;
      op("random", ra, rb, 1'($urandom), 1'($urandom));
    end

    wait_done(lat);
    chk("no spurious done", lat, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cla_seq_adder.md
Name: cla_seq_adder

Overview:
- Multi-cycle N-bit add/subtract unit that time-multiplexes one 4-bit carry-lookahead adder slice over the operand nibbles, LSB nibble first.
- Carry is registered between nibbles.
- Sits between a requester using a start/ready/done handshake and the shared 4-bit CLA datapath.
- Trades area for latency: WIDTH/4 compute cycles per operation.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 8.
- NIBS, WIDTH/4, derived nibble count; not overridable.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start_i  in  1  request; accepted only when ready_o=1.
- A_in  in  WIDTH  operand A, sampled on accept.
- B_in  in  WIDTH  operand B, sampled on accept.
- C_in  in  1  carry-in (add) / borrow-in (sub), sampled on accept.
- sub_i  in  1  0=A+B+C_in, 1=A-B-C_in, sampled on accept.
- ready_o  out  1  high only in IDLE.
- busy_o  out  1  high in RUN.
- done_o  out  1  one-cycle pulse when the result updates.
- Sum_o  out  WIDTH  registered result.
- C_out  out  1  add: carry-out; sub: 1 = no borrow (A ≥ B+C_in, unsigned).
- ovf_o  out  1  two's-complement signed overflow of the operation.

Behaviour:
- Reset (synchronous, rst=1 at an edge):
  - State goes to IDLE; nibble counter=0; work registers=0.
  - Sum_o=0, C_out=0, ovf_o=0, done_o=0, busy_o=0, ready_o=1 on the cycle after reset.
  - rst has priority over every other input.
- FSM states: IDLE, RUN, DONE.
  - IDLE→RUN when start_i=1 at edge t. In that cycle, latch:
    - a_q=A_in
    - b_q = sub_i ? ~B_in : B_in
    - cy_q = sub_i ? ~C_in : C_in
    - sub_q=sub_i
    - cnt=0
  - RUN, each cycle:
    - CLA slice adds a_q[3:0], b_q[3:0], cy_q.
    - Slice sum shifts into the top nibble of res_q; a_q and b_q shift right by 4.
    - cy_q takes the slice C_out; cnt increments.
  - RUN→DONE after the cycle where cnt=NIBS-1.
  - DONE, one cycle: Sum_o, C_out and ovf_o load from the working registers; done_o=1. Always → IDLE.
- Latency:
  - Accept at edge t; nibble k is computed in cycle t+1+k.
  - done_o is high and the new Sum_o/C_out/ovf_o are visible in cycle t+NIBS+1 (t+5 for WIDTH=16).
  - ready_o returns high at t+NIBS+2.
  - Throughput: one op per NIBS+2 cycles.
- Output stability:
  - Sum_o/C_out/ovf_o hold the previous result through RUN and change only in the DONE cycle.
  - They hold until the next DONE or reset.
- start_i while ready_o=0 is ignored; it is not queued and has no effect on the operation in flight.
- Operand inputs are don't-care except in the accept cycle.
- Overflow:
  - ovf_o = (A[W-1] == B'[W-1]) && (Sum[W-1] != A[W-1]), where B' is the post-inversion operand.
  - The MSBs used are the captured MSBs of A and B', held in dedicated flops at accept.
- Reset mid-RUN or mid-DONE aborts: no done_o pulse, outputs cleared per reset values.
- Arithmetic is modulo 2^WIDTH; no saturation.

Decomposition:
- Shared package cla_pkg holds:
  - NIB_W=4
  - FSM state encoding localparams: IDLE=2'd0, RUN=2'd1, DONE=2'd2
  - counter width helper $clog2(NIBS)
- One sub-module, cla4: purely combinational 4-bit carry-lookahead adder.
  - Ports: A_in[3:0], B_in[3:0], C_in, Sum_o[3:0], C_out.
  - Generate/propagate lookahead carries; no ripple.
  - Instantiated once in cla_seq_adder; verified standalone by exhaustive 512-vector check.
- Controller, shift registers and output registers live in cla_seq_adder.

Test Plan:
1. Basic add, WIDTH=16: A=0x1234, B=0x4321, C_in=0, sub=0, accept at t → done_o only at t+5, Sum_o=0x5555, C_out=0, ovf_o=0; ready_o high at t+6.
2. Full carry propagation: A=0xFFFF, B=0x0001, C_in=0 → Sum_o=0x0000, C_out=1, ovf_o=0. Also A=0x7FFF, B=0x0001 → Sum_o=0x8000, C_out=0, ovf_o=1.
3. Subtract:
   - 0x0005-0x0007 (C_in=0) → Sum_o=0xFFFE, C_out=0, ovf_o=0.
   - 0x8000-0x0001 → 0x7FFF, C_out=1, ovf_o=1.
   - 0x0010-0x000F with C_in=1 → 0x0000, C_out=1.
4. Handshake:
   - Pulse start_i with new operands at t+1..t+4 during RUN → ignored; result still equals the first op.
   - Sum_o keeps the prior result until t+5.
   - Back-to-back start at t+6 completes at t+11.
5. Reset mid-operation: assert rst at cycle t+2 → no done_o pulse; Sum_o=0, C_out=0, ovf_o=0, ready_o=1 next cycle; a fresh op then completes normally.
6. Random regression: 2000 random A/B/C_in/sub_i ops compared against a behavioural model ({C_out,Sum_o} vs A+B+C_in, or A-B-C_in with the borrow convention), plus exhaustive cla4 standalone → zero mismatches.
